imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the RV32I/RV64I datapath. Covers all base formats (I, shift, S, B, U, J).

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 187 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between fetch/decode and the ALU operand mux.
// The producer drives inst_* and the consumer drives imm_ready.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_code;
  logic            imm_valid;
  logic            imm_ready;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      imm_fmt;
  logic            illegal;

  // Generator side: takes instructions, presents decoded immediates.
  modport slave (
    input  inst_valid, inst_code, imm_ready,
    output inst_ready, imm_valid, imm_out, imm_fmt, illegal
  );

  // Environment side: offers instructions, consumes immediates.
  modport master (
    output inst_valid, inst_code, imm_ready,
    input  inst_ready, imm_valid, imm_out, imm_fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry elastic buffer.
// Slot head_q is always the entry presented on the outputs, so every output
// comes straight from a flop; the second slot only holds the overflow entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_NONE  = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd2;
  localparam logic [FMT_W-1:0] FMT_S     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_B     = 3'd4;
  localparam logic [FMT_W-1:0] FMT_U     = 3'd5;
  localparam logic [FMT_W-1:0] FMT_J     = 3'd6;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  entry_t           dec;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  logic [31:0]      inst;
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic             is_shift;

  assign inst     = bus.inst_code;
  assign opcode   = inst[6:0];
  assign f3       = inst[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Combinational decode of the incoming word into {imm, fmt, illegal}.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_IMM: begin
        if (is_shift) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.imm = XLEN'(inst[25:20]);
          else            dec.imm = XLEN'(inst[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(inst[31:20]));
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(inst[31:20]));
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec.fmt = FMT_SHAMT;
            dec.imm = XLEN'(inst[24:20]);
          end else begin
            dec.fmt = FMT_I;
            dec.imm = XLEN'($signed(inst[31:20]));
          end
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({inst[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      OP_REG: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Handshakes; ready comes from a flop, so imm_ready never reaches inst_ready.
  assign push = bus.inst_valid & ready_q;
  assign pop  = valid_q & bus.imm_ready;

  // Next-state for the buffer slots, occupancy, flags and illegal counter.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = dec;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d  = dec;
        end else if (push) begin
          tail_d  = dec;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
    if (push && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset flushes any buffered entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.inst_ready = ready_q;
  assign bus.imm_valid  = valid_q;
  assign bus.imm_out    = head_q.imm;
  assign bus.imm_fmt    = head_q.fmt;
  assign bus.illegal    = head_q.illegal;
  assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_pipe;

  logic       clk;
  logic       reset;
  logic [7:0] cnt32;
  logic [7:0] cnt64;
  int         checks;
  int         errors;
  int         exp_cnt;

  imm_gen_pipe_if #(.XLEN(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus32),
    .illegal_cnt (cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus64),
    .illegal_cnt (cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one word into the 32-bit instance, check the head, then drain it.
  task automatic push32(input string tag, input logic [31:0] code, input logic [31:0] ei,
                        input logic [2:0] ef, input logic el);
    bus32.inst_code  = code;
    bus32.inst_valid = 1'b1;
    bus32.imm_ready  = 1'b0;
    tick();
    bus32.inst_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus32.imm_valid), 64'(1));
    chk({tag, "_imm"}, 64'(bus32.imm_out), 64'(ei));
    chk({tag, "_fmt"}, 64'(bus32.imm_fmt), 64'(ef));
    chk({tag, "_ill"}, 64'(bus32.illegal), 64'(el));
    bus32.imm_ready = 1'b1;
    tick();
    chk({tag, "_drained"}, 64'(bus32.imm_valid), 64'(0));
    bus32.imm_ready = 1'b0;
  endtask

  task automatic push64(input string tag, input logic [31:0] code, input logic [63:0] ei,
                        input logic [2:0] ef, input logic el);
    bus64.inst_code  = code;
    bus64.inst_valid = 1'b1;
    bus64.imm_ready  = 1'b0;
    tick();
    bus64.inst_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus64.imm_valid), 64'(1));
    chk({tag, "_imm"}, bus64.imm_out, ei);
    chk({tag, "_fmt"}, 64'(bus64.imm_fmt), 64'(ef));
    chk({tag, "_ill"}, 64'(bus64.illegal), 64'(el));
    bus64.imm_ready = 1'b1;
    tick();
    chk({tag, "_drained"}, 64'(bus64.imm_valid), 64'(0));
    bus64.imm_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus32.inst_valid = 1'b0;
    bus32.inst_code  = 32'h0;
    bus32.imm_ready  = 1'b0;
    bus64.inst_valid = 1'b0;
    bus64.inst_code  = 32'h0;
    bus64.imm_ready  = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Reset state
    chk("rst_ready", 64'(bus32.inst_ready), 64'(1));
    chk("rst_valid", 64'(bus32.imm_valid), 64'(0));
    chk("rst_imm", 64'(bus32.imm_out), 64'(0));
    chk("rst_fmt", 64'(bus32.imm_fmt), 64'(0));
    chk("rst_ill", 64'(bus32.illegal), 64'(0));
    chk("rst_cnt", 64'(cnt32), 64'(0));

    // Decode vectors, XLEN=32
    push32("addi_m1", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    push32("srai_5",  32'h40515093, 32'h00000005, 3'd2, 1'b0);
    push32("slli_b25", 32'h03F11093, 32'h0000001F, 3'd2, 1'b0);
    push32("lw_neg",  32'h80012083, 32'hFFFFF800, 3'd1, 1'b0);
    push32("sw_m4",   32'hFE112E23, 32'hFFFFFFFC, 3'd3, 1'b0);
    push32("beq_a",   32'hFE000EE3, 32'hFFFFFFFC, 3'd4, 1'b0);
    push32("beq_b",   32'hFE000E63, 32'hFFFFF7FC, 3'd4, 1'b0);
    push32("jal",     32'h800000EF, 32'hFFF00000, 3'd6, 1'b0);
    push32("lui",     32'h123450B7, 32'h12345000, 3'd5, 1'b0);
    push32("auipc",   32'hFFFFF097, 32'hFFFFF000, 3'd5, 1'b0);
    push32("add_r",   32'h002081B3, 32'h00000000, 3'd0, 1'b0);
    push32("opimm32", 32'h0000001B, 32'h00000000, 3'd0, 1'b1);
    push32("op_zero", 32'h00000000, 32'h00000000, 3'd0, 1'b1);
    chk("cnt_after2", 64'(cnt32), 64'(2));

    // Decode vectors, XLEN=64
    push64("slli63",  32'h03F11093, 64'h000000000000003F, 3'd2, 1'b0);
    push64("slliw",   32'h03F1109B, 64'h000000000000001F, 3'd2, 1'b0);
    push64("addiw",   32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    push64("lui64",   32'h800000B7, 64'hFFFFFFFF80000000, 3'd5, 1'b0);
    chk("cnt64_zero", 64'(cnt64), 64'(0));

    // Backpressure: three back-to-back pushes with imm_ready held low
    bus32.imm_ready  = 1'b0;
    bus32.inst_valid = 1'b1;
    bus32.inst_code  = 32'hFFF00093;
    tick();
    chk("bp_ready1", 64'(bus32.inst_ready), 64'(1));
    bus32.inst_code  = 32'h40515093;
    tick();
    chk("bp_ready2", 64'(bus32.inst_ready), 64'(0));
    bus32.inst_code  = 32'h123450B7;
    tick();
    chk("bp_hold_ready", 64'(bus32.inst_ready), 64'(0));
    chk("bp_hold_imm", 64'(bus32.imm_out), 64'hFFFFFFFF);
    chk("bp_hold_fmt", 64'(bus32.imm_fmt), 64'(1));
    bus32.imm_ready = 1'b1;
    tick();
    chk("bp_head2_imm", 64'(bus32.imm_out), 64'h5);
    chk("bp_head2_fmt", 64'(bus32.imm_fmt), 64'(2));
    chk("bp_ready_back", 64'(bus32.inst_ready), 64'(1));
    tick();
    bus32.inst_valid = 1'b0;
    chk("bp_head3_valid", 64'(bus32.imm_valid), 64'(1));
    chk("bp_head3_imm", 64'(bus32.imm_out), 64'h12345000);
    chk("bp_head3_fmt", 64'(bus32.imm_fmt), 64'(5));
    tick();
    chk("bp_empty", 64'(bus32.imm_valid), 64'(0));

    // Illegal stream at full rate, counter saturation
    exp_cnt = 2;
    bus32.imm_ready  = 1'b1;
    bus32.inst_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus32.inst_code = 32'(i) << 7;
      tick();
      if (exp_cnt < 255) exp_cnt++;
      chk("ill_valid", 64'(bus32.imm_valid), 64'(1));
      chk("ill_flag", 64'(bus32.illegal), 64'(1));
      chk("ill_imm", 64'(bus32.imm_out), 64'(0));
      chk("ill_fmt", 64'(bus32.imm_fmt), 64'(0));
      chk("ill_cnt", 64'(cnt32), 64'(exp_cnt));
    end
    bus32.inst_valid = 1'b0;
    tick();
    chk("ill_drained", 64'(bus32.imm_valid), 64'(0));
    chk("ill_cnt_sat", 64'(cnt32), 64'(255));

    // Reset with a full buffer
    bus32.imm_ready  = 1'b0;
    bus32.inst_valid = 1'b1;
    bus32.inst_code  = 32'hFFF00093;
    tick();
    bus32.inst_code  = 32'h40515093;
    tick();
    bus32.inst_valid = 1'b0;
    chk("full_ready", 64'(bus32.inst_ready), 64'(0));
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(bus32.imm_valid), 64'(0));
    chk("arst_cnt", 64'(cnt32), 64'(0));
    chk("arst_imm", 64'(bus32.imm_out), 64'(0));
    chk("arst_fmt", 64'(bus32.imm_fmt), 64'(0));
    tick();
    reset = 1'b1;
    tick();
    chk("post_ready", 64'(bus32.inst_ready), 64'(1));
    chk("post_valid", 64'(bus32.imm_valid), 64'(0));
    bus32.imm_ready = 1'b1;
    tick();
    chk("post_no_stale", 64'(bus32.imm_valid), 64'(0));
    push32("post_lui", 32'h123450B7, 32'h12345000, 3'd5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
